rv32i_alu: RTL and testbench
============================

# rv32i_alu

The RV32I integer ALU computes one of ten register-register operations on two 32-bit operands. The result is registered, so `rd` holds the result of the inputs sampled at the previous rising clock edge. The block sits in the CPU execute stage. The decoder drives `op` directly from instruction bits {funct7[5], funct3}.

## Interface
- No parameters. Data width is fixed at 32 bits.
- `clk  input  1`: clock; all state updates on the rising edge.
- `rst_n  input  1`: reset, asynchronous and active-low.
- `rs1  input  32`: first operand.
- `rs2  input  32`: second operand; supplies the shift amount for shift ops.
- `op  input  4`: operation select, {funct7[5], funct3}.
- `rd  output  32`: registered result.

## Operation
- `op` decode; all arithmetic is modulo 2^32:
  - 0000 ADD: rs1 + rs2, carry discarded.
  - 1000 SUB: rs1 − rs2, borrow discarded.
  - 0001 SLL: rs1 << rs2[4:0].
  - 0010 SLT: 1 if $signed(rs1) < $signed(rs2), else 0; zero-extended to 32 bits.
  - 0011 SLTU: 1 if rs1 < rs2 unsigned, else 0.
  - 0100 XOR: rs1 ^ rs2.
  - 0101 SRL: rs1 >> rs2[4:0], zero fill.
  - 1101 SRA: rs1 >> rs2[4:0], fill with rs1[31].
  - 0110 OR: rs1 | rs2.
  - 0111 AND: rs1 & rs2.
- Unassigned codes (1001, 1010, 1011, 1100, 1110, 1111) produce result 0.
- Shifts use only rs2[4:0]; rs2[31:5] is ignored, so a shift by 32 is a shift by 0.
- No flags and no exceptions; overflow is silently wrapped.
- Result logic is purely combinational from rs1, rs2 and op, feeding a single 32-bit output register.

## Timing
- While `rst_n` = 0, `rd` = 0x0000_0000. This takes effect immediately, independent of `clk`.
- On `rst_n` deassertion, `rd` stays 0 until the first rising edge with `rst_n` = 1.
- Latency is 1 cycle: inputs present at rising edge N appear on `rd` after edge N and hold until edge N+1.
- Throughput is one operation per cycle. There is no handshake or stall; a new result is captured every edge.
- Inputs changing between edges do not affect `rd`, so `rd` is glitch-free.
- Reset asserted mid-stream discards the in-flight result. The first post-reset result is the one sampled at the first active edge.

## Test plan
- Reset: hold `rst_n` = 0 with rs1=4, rs2=3, op=0000 and toggle `clk` → `rd` stays 0. Assert `rst_n` between edges while `rd`=7 → `rd` becomes 0 immediately, without waiting for an edge.
- Full sweep with rs1=4, rs2=3, op=0..15, one op per cycle → `rd` one cycle later, per op:
  - ADD 7, SUB 1, SLL 32, SLT 0, SLTU 0, XOR 7, SRL 0, SRA 0, OR 7, AND 0.
  - All unassigned codes 0.
- Signedness with rs1=0x8000_0000, rs2=1:
  - SLT 1, SLTU 0.
  - SRL 0x4000_0000, SRA 0xC000_0000.
  - SUB 0x7FFF_FFFF.
- Shift masking with rs1=0x0000_0001:
  - rs2=33, SLL → 0x0000_0002.
  - rs2=32, SLL → 0x0000_0001.
  - rs1=0xFFFF_FFFF, rs2=31, SRA → 0xFFFF_FFFF; SRL → 0x0000_0001.
- Wrap-around:
  - ADD 0xFFFF_FFFF + 1 → 0.
  - SUB 0 − 1 → 0xFFFF_FFFF.
  - SLTU 0 vs 0xFFFF_FFFF → 1; SLT same operands → 0.
- Back-to-back latency: change op on every edge (ADD, SUB, XOR) with rs1=10, rs2=6 → `rd` sequence 16, 4, 12 on consecutive cycles, each delayed exactly one edge. Mid-cycle input changes leave `rd` unchanged.

Source files
------------

// File: rtl/rv32i_alu.sv
// rv32i_alu: RV32I register-register ALU with a registered 32-bit result.
//   clk   - clock, result captured on the rising edge
//   rst_n - asynchronous active-low reset, clears rd
//   rs1   - first operand
//   rs2   - second operand; rs2[4:0] is the shift amount for shifts
//   op    - {funct7[5], funct3} operation select
//   rd    - result of the operands sampled at the previous rising edge
module rv32i_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [3:0]  op,
    output logic [31:0] rd
);
    logic [4:0]  shamt;
    logic [31:0] result;
    assign shamt = rs2[4:0];
    always_comb begin
        result = '0;
        case (op)
            4'b0000: result = rs1 + rs2;
            4'b1000: result = rs1 - rs2;
            4'b0001: result = rs1 << shamt;
            4'b0010: result = {31'd0, $signed(rs1) < $signed(rs2)};
            4'b0011: result = {31'd0, rs1 < rs2};
            4'b0100: result = rs1 ^ rs2;
            4'b0101: result = rs1 >> shamt;
            4'b1101: result = $unsigned($signed(rs1) >>> shamt);
            4'b0110: result = rs1 | rs2;
            4'b0111: result = rs1 & rs2;
            default: result = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd <= '0;
        else
            rd <= result;
    end
endmodule

// File: tb/tb_rv32i_alu.sv
// tb_rv32i_alu: directed scoreboard bench for rv32i_alu.
module tb_rv32i_alu;
    logic        clk;
    logic        rst_n;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  op;
    logic [31:0] rd;
    logic [31:0] sb[$];
    logic [31:0] last_exp;
    int          errors;
    int          checks;

    rv32i_alu dut (.clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .op(op), .rd(rd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (rd === exp)
        else begin
            errors++;
            $error("FAIL %s: rd=%h expected=%h", tag, rd, exp);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o,
                        input logic [31:0] e, input string tag);
        @(negedge clk);
        rs1 = a;
        rs2 = b;
        op  = o;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            last_exp = sb.pop_front();
            check(tag, last_exp);
        end
    endtask

    task automatic glitch(input string tag);
        rs1 = rs1 ^ 32'h5A5A_1234;
        op  = op + 4'd3;
        #2;
        check(tag, last_exp);
    endtask

    initial begin
        logic [31:0] sweep [16];
        errors = 0;
        checks = 0;
        rst_n = 1'b1;
        rs1 = 32'd4;
        rs2 = 32'd3;
        op  = 4'b0000;
        #1 rst_n = 1'b0;
        #1 check("reset_async_init", 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1 check("reset_hold", 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset_release_no_edge", 32'd0);
        step(32'd4, 32'd3, 4'b0000, 32'd7, "first_after_reset");
        rst_n = 1'b0;
        #1 check("reset_async_mid", 32'd0);
        @(posedge clk);
        #1 check("reset_mid_hold", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(32'd10, 32'd6, 4'b0000, 32'd16, "post_reset_first");

        sweep = '{32'd7, 32'd32, 32'd0, 32'd0, 32'd7, 32'd0, 32'd7, 32'd0,
                  32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 16; i++)
            step(32'd4, 32'd3, 4'(i), sweep[i], $sformatf("sweep_op%0d", i));

        step(32'h8000_0000, 32'd1, 4'b0010, 32'd1,           "sign_slt");
        step(32'h8000_0000, 32'd1, 4'b0011, 32'd0,           "sign_sltu");
        step(32'h8000_0000, 32'd1, 4'b0101, 32'h4000_0000,   "sign_srl");
        step(32'h8000_0000, 32'd1, 4'b1101, 32'hC000_0000,   "sign_sra");
        step(32'h8000_0000, 32'd1, 4'b1000, 32'h7FFF_FFFF,   "sign_sub");

        step(32'd1, 32'd33, 4'b0001, 32'd2,                  "shamt_sll33");
        step(32'd1, 32'd32, 4'b0001, 32'd1,                  "shamt_sll32");
        step(32'hFFFF_FFFF, 32'd31, 4'b1101, 32'hFFFF_FFFF,  "shamt_sra31");
        step(32'hFFFF_FFFF, 32'd31, 4'b0101, 32'd1,          "shamt_srl31");
        step(32'h8765_4321, 32'hFFFF_FFE4, 4'b0101, 32'h0876_5432, "shamt_srl_hi_bits");

        step(32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0,           "wrap_add");
        step(32'd0, 32'd1, 4'b1000, 32'hFFFF_FFFF,           "wrap_sub");
        step(32'd0, 32'hFFFF_FFFF, 4'b0011, 32'd1,           "wrap_sltu");
        step(32'd0, 32'hFFFF_FFFF, 4'b0010, 32'd0,           "wrap_slt");
        step(32'hF0F0_1234, 32'h0FF0_FF00, 4'b0110, 32'hFFF0_FF34, "or_pattern");
        step(32'hF0F0_1234, 32'h0FF0_FF00, 4'b0111, 32'h00F0_1200, "and_pattern");
        step(32'hF0F0_1234, 32'h0FF0_FF00, 4'b0100, 32'hFF00_ED34, "xor_pattern");

        step(32'd10, 32'd6, 4'b0000, 32'd16, "b2b_add");
        glitch("b2b_add_glitch");
        step(32'd10, 32'd6, 4'b1000, 32'd4,  "b2b_sub");
        glitch("b2b_sub_glitch");
        step(32'd10, 32'd6, 4'b0100, 32'd12, "b2b_xor");
        glitch("b2b_xor_glitch");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
